// File: rtl/peer_link_pkg.sv
// Shared definitions for the board-to-board game link (frame layout, FSM states).
package peer_link_pkg;

    localparam int FRAME_BITS  = 13;
    localparam int DATA_BITS   = 10;

    localparam int SCORE_LSB   = 0;
    localparam int STATE_LSB   = 6;
    localparam int ADDLINE_BIT = 9;

    localparam int SCORE_W     = 6;
    localparam int STATE_W     = 3;

    typedef enum logic [2:0] {
        HUNT,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } pl_state_e;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/peer_link_sync.sv
// Two-flop synchronizer for the peer serial line plus falling-edge detect.
module peer_link_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle-high line: resetting to 1 avoids a false start edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign line_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/peer_link_rx.sv
// Peer link receiver: 13-bit frames into score/state/add-line outputs.
// Optional watchdog enabled by defining PEER_LINK_TIMEOUT_EN.
module peer_link_rx
    import peer_link_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 400,
    parameter int TIMEOUT_CYCLES = 40000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_line,
    output logic [SCORE_W-1:0] score_in,
    output logic [STATE_W-1:0] state_in,
    output logic               add_line_req,
    output logic               frame_valid,
    output logic               frame_err,
    output logic               link_alive
);

    localparam int CW = $clog2(FRAME_BITS * CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HUNT_END = CW'(FRAME_BITS * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    logic line;
    logic fall;

    pl_state_e state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [STATE_W-1:0]   stat_q, stat_d;
    logic                 alive_q, alive_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 add_q, add_d;
    logic                 bit_tick;
    logic                 wd_sat;

    peer_link_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (rx_line),
        .line_o (line),
        .fall_o (fall)
    );

    assign bit_tick = (cnt_q == BIT_END);

`ifdef PEER_LINK_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);

    logic [WW-1:0] wd_q, wd_d;

    assign wd_sat = (wd_q == WD_MAX);

    always_comb begin
        wd_d = wd_q;
        if (valid_d) begin
            wd_d = '0;
        end else if (!wd_sat) begin
            wd_d = wd_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout;

    assign wd_sat         = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        score_d = score_q;
        stat_d  = stat_q;
        alive_d = alive_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        add_d   = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (!line) begin
                    cnt_d = '0;
                end else if (cnt_q == HUNT_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    state_d = line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    par_d   = line;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (line && (even_parity(shift_q) == par_q)) begin
                        score_d = shift_q[SCORE_LSB +: SCORE_W];
                        stat_d  = shift_q[STATE_LSB +: STATE_W];
                        alive_d = 1'b1;
                        valid_d = 1'b1;
                        add_d   = shift_q[ADDLINE_BIT];
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = HUNT;
            end
        endcase

        // A silent peer drops the link; score is kept for display.
        if (wd_sat && !valid_d) begin
            alive_d = 1'b0;
            stat_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            score_q <= '0;
            stat_q  <= '0;
            alive_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            add_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            score_q <= score_d;
            stat_q  <= stat_d;
            alive_q <= alive_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            add_q   <= add_d;
        end
    end

    assign score_in     = score_q;
    assign state_in     = stat_q;
    assign add_line_req = add_q;
    assign frame_valid  = valid_q;
    assign frame_err    = err_q;
    assign link_alive   = alive_q;

endmodule

// File: tb/tb_peer_link_rx.sv
// Self-checking bench for peer_link_rx: vector table, corner sequences, random frames.
module tb_peer_link_rx;

    localparam int C  = 16;
    localparam int TO = 2000;
    localparam int RS = 13 * C + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic [5:0] score_in;
    logic [2:0] state_in;
    logic       add_line_req;
    logic       frame_valid;
    logic       frame_err;
    logic       link_alive;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nvalid = 0;
    int nerr = 0;
    int nadd = 0;
    int nexcl = 0;
    int last_valid_cyc = 0;

    int m_score = 0;
    int m_state = 0;
    int m_alive = 0;
    bit m_hunt = 1'b1;

    typedef struct {
        int sc;
        int st;
        int ad;
        int kind;
        int gap;
        int ev;
        int ee;
        int ea;
        int es;
        int est;
        int eal;
    } vec_t;

    vec_t tbl[10];

    peer_link_rx #(
        .CLKS_PER_BIT   (C),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_line      (rx_line),
        .score_in     (score_in),
        .state_in     (state_in),
        .add_line_req (add_line_req),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .link_alive   (link_alive)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            nvalid++;
            last_valid_cyc = cyc;
        end
        if (frame_err) nerr++;
        if (add_line_req) nadd++;
        if (frame_valid && frame_err) nexcl++;
        if (add_line_req && !frame_valid) nexcl++;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic hold(input logic b, input int n);
        rx_line = b;
        repeat (n) @(negedge clk);
    endtask

    // kind: 0 good, 1 parity bit inverted, 2 stop bit low
    function automatic logic [12:0] mk_frame(input int sc, input int st,
                                             input int ad, input int kind);
        logic [9:0] d;
        logic       p;
        logic       sb;
        int         ones;
        d    = {ad[0], st[2:0], sc[5:0]};
        ones = 0;
        for (int i = 0; i < 10; i++) ones += int'(d[i]);
        p  = (ones % 2) != 0;
        if (kind == 1) p = ~p;
        sb = (kind != 2);
        return {sb, p, d, 1'b0};
    endfunction

    task automatic send(input logic [12:0] f);
        for (int i = 0; i < 13; i++) hold(f[i], C);
    endtask

    task automatic run_frame(input string tag, input int sc, input int st,
                             input int ad, input int kind, input int gap,
                             input int ev, input int ee, input int ea,
                             input int es, input int est, input int eal);
        int v0;
        int e0;
        int a0;
        v0 = nvalid;
        e0 = nerr;
        a0 = nadd;
        hold(1'b1, gap);
        send(mk_frame(sc, st, ad, kind));
        chk({tag, ".valid"}, nvalid - v0, ev);
        chk({tag, ".err"}, nerr - e0, ee);
        chk({tag, ".add"}, nadd - a0, ea);
        chk({tag, ".score"}, int'(score_in), es);
        chk({tag, ".state"}, int'(state_in), est);
        chk({tag, ".alive"}, int'(link_alive), eal);
    endtask

    // Reference: receiver is deaf after reset or a bad frame until it has
    // seen a full frame time of idle line; good frames update the outputs.
    task automatic model_frame(input string tag, input int sc, input int st,
                               input int ad, input int kind, input int gap);
        int ev;
        int ee;
        int ea;
        ev = 0;
        ee = 0;
        ea = 0;
        if (m_hunt && gap >= RS) m_hunt = 1'b0;
        if (!m_hunt) begin
            if (kind == 0) begin
                ev = 1;
                ea = ad;
                m_score = sc;
                m_state = st;
                m_alive = 1;
            end else begin
                ee = 1;
                m_hunt = 1'b1;
            end
        end
        run_frame(tag, sc, st, ad, kind, gap, ev, ee, ea,
                  m_score, m_state, m_alive);
    endtask

    initial begin
        int t1;
        int v0;
        int e0;
        int sc;
        int st;
        int ad;
        int kind;
        int gap;

        tbl[0] = '{37, 2, 0, 0, RS, 1, 0, 0, 37, 2, 1};
        tbl[1] = '{ 5, 1, 1, 0,  0, 1, 0, 1,  5, 1, 1};
        tbl[2] = '{ 6, 1, 0, 0,  0, 1, 0, 0,  6, 1, 1};
        tbl[3] = '{20, 3, 0, 1,  5, 0, 1, 0,  6, 1, 1};
        tbl[4] = '{50, 5, 1, 0,  0, 0, 0, 0,  6, 1, 1};
        tbl[5] = '{63, 7, 0, 0, RS, 1, 0, 0, 63, 7, 1};
        tbl[6] = '{ 0, 0, 0, 0,  0, 1, 0, 0,  0, 0, 1};
        tbl[7] = '{63, 7, 1, 0,  3, 1, 0, 1, 63, 7, 1};
        tbl[8] = '{11, 4, 0, 2,  3, 0, 1, 0, 63, 7, 1};
        tbl[9] = '{12, 5, 1, 0, RS, 1, 0, 1, 12, 5, 1};

        t1 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst.score", int'(score_in), 0);
        chk("rst.state", int'(state_in), 0);
        chk("rst.alive", int'(link_alive), 0);
        chk("rst.pulses", int'({frame_valid, frame_err, add_line_req}), 0);

        for (int i = 0; i < 10; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].sc, tbl[i].st,
                      tbl[i].ad, tbl[i].kind, tbl[i].gap, tbl[i].ev,
                      tbl[i].ee, tbl[i].ea, tbl[i].es, tbl[i].est,
                      tbl[i].eal);
            if (i == 1) t1 = last_valid_cyc;
            if (i == 2) chk("b2b.spacing", last_valid_cyc - t1, 13 * C);
        end
        m_score = 12;
        m_state = 5;
        m_alive = 1;
        m_hunt  = 1'b0;

        v0 = nvalid;
        e0 = nerr;
        hold(1'b1, C);
        hold(1'b0, 4);
        hold(1'b1, 2 * C);
        chk("glitch.valid", nvalid - v0, 0);
        chk("glitch.err", nerr - e0, 0);
        model_frame("glitch.next", 33, 3, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            sc   = int'($urandom_range(0, 63));
            st   = int'($urandom_range(0, 7));
            ad   = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            kind = (kind == 0) ? 1 : ((kind == 1) ? 2 : 0);
            gap  = m_hunt ? RS : int'($urandom_range(0, 2 * C));
            model_frame($sformatf("rnd%0d", n), sc, st, ad, kind, gap);
        end

        model_frame("prerst", 42, 6, 0, 0, m_hunt ? RS : 2);
        v0 = nvalid;
        e0 = nerr;
        begin
            logic [12:0] f;
            f = mk_frame(21, 3, 1, 0);
            for (int i = 0; i < 6; i++) hold(f[i], C);
            hold(f[6], C / 2);
        end
        rst = 1'b1;
        rx_line = 1'b1;
        @(negedge clk);
        chk("midrst.score", int'(score_in), 0);
        chk("midrst.state", int'(state_in), 0);
        chk("midrst.alive", int'(link_alive), 0);
        rst = 1'b0;
        m_score = 0;
        m_state = 0;
        m_alive = 0;
        m_hunt  = 1'b1;
        model_frame("postrst", 21, 3, 1, 0, RS);
        chk("midrst.nopulse", nerr - e0, 0);

`ifdef PEER_LINK_TIMEOUT_EN
        model_frame("wd.pre", 17, 4, 0, 0, 5);
        hold(1'b1, TO + 20);
        chk("wd.alive", int'(link_alive), 0);
        chk("wd.state", int'(state_in), 0);
        chk("wd.score", int'(score_in), 17);
        m_state = 0;
        m_alive = 0;
        model_frame("wd.post", 9, 2, 0, 0, 3);
`endif

        chk("exclusive", nexcl, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
